mpu_6050_i2c_target: RTL and testbench
======================================

# mpu_6050_i2c_target

Synthesizable I2C target (slave) that emulates the MPU-6050 register interface at the far end of the bus driven by our MPU_6050 I2C master. It decodes START/STOP, matches its 7-bit device address, and serves single and burst register reads and writes from a 128-byte register file. It is used for on-FPGA loopback and bench verification of the master without a physical sensor. Fabric logic can preload sensor data registers through a side port.

## Interface
- DEV_ADDR, 7'h68, 7-bit I2C device address.
- WHO_AM_I, 8'h68, read-only value returned at register 0x75.
- CLK  input  1  system clock, 50 MHz; all logic on posedge.
- RST_n  input  1  asynchronous, active-low reset.
- IO_SCL  input  1  I2C serial clock; never driven, no clock stretching.
- IO_SDA  inout  1  I2C data; open-drain: driven 0 or high-Z only.
- I_LD_EN  input  1  fabric register-load strobe, one write per cycle.
- I_LD_ADDR  input  7  fabric load register address.
- I_LD_DATA  input  8  fabric load data.
- O_WR_STB  output  1  one-cycle pulse per register byte written over I2C.
- O_WR_ADDR  output  7  register address of the last I2C write.
- O_WR_DATA  output  8  data of the last I2C write.
- O_BUSY  output  1  high while addressed: from address ACK to STOP or repeated START.

## Operation
- SCL/SDA pass through 2-FF synchronizers. Edges are detected on the synchronized copies.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are honoured in every state. START (including repeated start) goes to ADDR. STOP goes to IDLE. Either one releases SDA.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- ADDR: shift 8 bits MSB first on SCL rising edges.
  - If byte[7:1] == DEV_ADDR, go to ADDR_ACK and drive ACK.
  - Otherwise go to IGNORE: SDA stays released until the next START or STOP.
- Address byte R/W bit:
  - R/W=0: REG. The first byte after the address is the register pointer. ptr = byte[6:0]; bit 7 is ignored. The pointer byte is ACKed, then the block enters WDATA.
  - R/W=1: RDATA, starting at the current ptr. ptr persists across transactions and repeated starts.
- WDATA:
  - Each received byte is ACKed and written to reg[ptr], and O_WR_STB/ADDR/DATA are updated.
  - A write to 0x75 is ACKed, but the register is unchanged and no strobe is issued.
  - ptr then increments modulo 128 (0x7F wraps to 0x00).
- RDATA: shift out reg[ptr] MSB first (0x75 always returns WHO_AM_I). ptr increments modulo 128 after the 8th bit. RDATA_ACK then samples the master bit:
  - ACK (0): next byte.
  - NACK (1): IGNORE.
- Register reset values: all 0x00 except 0x6B = 0x40.
- Fabric load: when I_LD_EN is high, reg[I_LD_ADDR] = I_LD_DATA (0x75 excluded). If a fabric load and an I2C write hit the same address in the same cycle, the I2C write wins.
- Reset, including mid-transfer:
  - SDA released immediately (asynchronously); state IDLE; ptr 0.
  - O_WR_STB 0, O_WR_ADDR 0, O_WR_DATA 0, O_BUSY 0.
  - Register file returns to its reset values.

## Timing
- Input latency: 2 sync cycles plus 1 edge-detect cycle. An SCL or SDA event is acted on 3 CLK cycles after the pin changes.
- Data bits are sampled on the detected SCL rising edge.
- SDA output changes only on the detected SCL falling edge (3 CLK, about 60 ns, after the pin fall). This guarantees SDA never changes while SCL is high.
- ACK: SDA is pulled low on the fall that ends bit 8 and released on the fall that ends bit 9.
- Read: the first data MSB is driven on the fall that ends the address ACK. Each following MSB is driven on the fall that ends the master ACK. SDA is released on the fall that ends bit 8 so the master can ACK/NACK.
- O_WR_STB pulses in the CLK cycle after the SCL rise that samples bit 8 of a data byte. It therefore precedes the ACK bit. The register file updates in the same cycle.
- O_BUSY rises on the fall that starts the address ACK.

## Test plan
- Reset, then S, 0xD0, 0x75, Sr, 0xD1, read 1 byte, NACK, P -> every byte ACKed; data 0x68; SDA released after the byte; O_BUSY falls at P.
- Reset, then read register 0x6B -> 0x40. Then write S, 0xD0, 0x6B, 0x00, 0x12, P -> two O_WR_STB pulses (6B/00, 6C/12). Reading back 0x6B, 0x6C -> 0x00, 0x12.
- Address 0xD2 (device 0x69) -> SDA high at the 9th clock (NACK); no strobe; O_BUSY stays 0. The bus is ignored until P.
- Pointer wrap: write ptr 0x7F with data 0xA5, 0x5A -> reg 0x7F=A5, 0x00=5A. A 3-byte burst read from 0x7E, with the master ACK/ACK/NACK -> xx, A5, 5A.
- I_LD_EN loads 0x3B=0x12 -> an I2C read of 0x3B returns 0x12. A simultaneous I_LD and I2C write to 0x3C (LD 0x11, I2C 0x22) -> reg 0x3C = 0x22.
- Assert RST_n low during a read bit that is driving 0 -> SDA goes high-Z in the same cycle. After release, a new START/read works normally.

Source files
------------

// File: rtl/mpu_6050_i2c_target.sv
// MPU-6050 register-interface emulator on an I2C target: 7-bit address match,
// register pointer, burst read/write over a 128-byte register file, fabric preload port.
`timescale 1ns/1ps
module mpu_6050_i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h68,
    parameter logic [7:0] WHO_AM_I = 8'h68
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       IO_SCL,
    inout  wire        IO_SDA,
    input  logic       I_LD_EN,
    input  logic [6:0] I_LD_ADDR,
    input  logic [7:0] I_LD_DATA,
    output logic       O_WR_STB,
    output logic [6:0] O_WR_ADDR,
    output logic [7:0] O_WR_DATA,
    output logic       O_BUSY
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_REG       = 4'd3;
    localparam logic [3:0] S_REG_ACK   = 4'd4;
    localparam logic [3:0] S_WDATA     = 4'd5;
    localparam logic [3:0] S_WDATA_ACK = 4'd6;
    localparam logic [3:0] S_RDATA     = 4'd7;
    localparam logic [3:0] S_RDATA_ACK = 4'd8;
    localparam logic [3:0] S_IGNORE    = 4'd9;

    localparam logic [6:0] WHO_AM_I_REG = 7'h75;

    logic       scl_s1_q, scl_s2_q, scl_p_q;
    logic       sda_s1_q, sda_s2_q, sda_p_q;
    logic       scl_rise, scl_fall, bus_start, bus_stop;

    logic [3:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] sh_q, sh_d;
    logic [6:0] ptr_q, ptr_d;
    logic       oe_q, oe_d;
    logic       busy_q, busy_d;
    logic       rw_q, rw_d;
    logic       stb_q, stb_d;
    logic [6:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       reg_we;

    logic [7:0] regs_q [128];
    logic [7:0] in_byte;
    logic [7:0] rd_byte;

    // Synchronizers reset to the idle-high bus level so reset release never fakes an edge.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_p_q  <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_p_q  <= 1'b1;
        end else begin
            scl_s1_q <= IO_SCL;
            scl_s2_q <= scl_s1_q;
            scl_p_q  <= scl_s2_q;
            sda_s1_q <= IO_SDA;
            sda_s2_q <= sda_s1_q;
            sda_p_q  <= sda_s2_q;
        end
    end

    assign scl_rise  = scl_s2_q & ~scl_p_q;
    assign scl_fall  = ~scl_s2_q & scl_p_q;
    assign bus_start = scl_s2_q & scl_p_q & sda_p_q & ~sda_s2_q;
    assign bus_stop  = scl_s2_q & scl_p_q & ~sda_p_q & sda_s2_q;

    assign in_byte = {sh_q[6:0], sda_s2_q};
    assign rd_byte = (ptr_q == WHO_AM_I_REG) ? WHO_AM_I : regs_q[ptr_q];

    // In the *_ACK states oe_q doubles as the phase flag: first fall pulls SDA low, second releases it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        ptr_d     = ptr_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        rw_d      = rw_q;
        stb_d     = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        reg_we    = 1'b0;
        if (bus_start) begin
            state_d = S_ADDR;
            cnt_d   = '0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (bus_stop) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: if (scl_rise) begin
                    sh_d  = in_byte;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d = '0;
                        rw_d  = in_byte[0];
                        state_d = (in_byte[7:1] == DEV_ADDR) ? S_ADDR_ACK : S_IGNORE;
                    end
                end
                S_ADDR_ACK: if (scl_fall) begin
                    if (!oe_q) begin
                        oe_d   = 1'b1;
                        busy_d = 1'b1;
                    end else if (rw_q) begin
                        sh_d    = rd_byte;
                        oe_d    = ~rd_byte[7];
                        cnt_d   = '0;
                        state_d = S_RDATA;
                    end else begin
                        oe_d    = 1'b0;
                        cnt_d   = '0;
                        state_d = S_REG;
                    end
                end
                S_REG: if (scl_rise) begin
                    sh_d  = in_byte;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d   = '0;
                        ptr_d   = in_byte[6:0];
                        state_d = S_REG_ACK;
                    end
                end
                S_REG_ACK, S_WDATA_ACK: if (scl_fall) begin
                    if (!oe_q) begin
                        oe_d = 1'b1;
                    end else begin
                        oe_d    = 1'b0;
                        cnt_d   = '0;
                        state_d = S_WDATA;
                    end
                end
                S_WDATA: if (scl_rise) begin
                    sh_d  = in_byte;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d   = '0;
                        ptr_d   = ptr_q + 7'd1;
                        state_d = S_WDATA_ACK;
                        if (ptr_q != WHO_AM_I_REG) begin
                            reg_we    = 1'b1;
                            stb_d     = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = in_byte;
                        end
                    end
                end
                S_RDATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) ptr_d = ptr_q + 7'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            state_d = S_RDATA_ACK;
                        end else begin
                            sh_d = {sh_q[6:0], 1'b0};
                            oe_d = ~sh_q[6];
                        end
                    end
                end
                S_RDATA_ACK: begin
                    if (scl_rise && sda_s2_q) begin
                        state_d = S_IGNORE;
                    end else if (scl_fall) begin
                        sh_d    = rd_byte;
                        oe_d    = ~rd_byte[7];
                        cnt_d   = '0;
                        state_d = S_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            ptr_q     <= '0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            rw_q      <= 1'b0;
            stb_q     <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            ptr_q     <= ptr_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            rw_q      <= rw_d;
            stb_q     <= stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // The I2C write is applied last so it overrides a same-address fabric load.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int unsigned i = 0; i < 128; i++)
                regs_q[i[6:0]] <= (i == 32'h6B) ? 8'h40 : 8'h00;
        end else begin
            if (I_LD_EN && (I_LD_ADDR != WHO_AM_I_REG)) regs_q[I_LD_ADDR] <= I_LD_DATA;
            if (reg_we) regs_q[ptr_q] <= in_byte;
        end
    end

    assign IO_SDA    = oe_q ? 1'b0 : 1'bz;
    assign O_WR_STB  = stb_q;
    assign O_WR_ADDR = wr_addr_q;
    assign O_WR_DATA = wr_data_q;
    assign O_BUSY    = busy_q;

endmodule

// File: tb/tb_mpu_6050_i2c_target.sv
// Bench for mpu_6050_i2c_target: bit-banged I2C master against a transaction-level
// register-file model, directed scenarios followed by randomized traffic.
`timescale 1ns/1ps
module tb_mpu_6050_i2c_target;

    localparam int T = 6;

    logic       CLK = 1'b0;
    logic       RST_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       ld_en = 1'b0;
    logic [6:0] ld_addr = '0;
    logic [7:0] ld_data = '0;
    wire        sda_bus;
    logic       wr_stb;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    assign sda_bus = m_sda ? 1'bz : 1'b0;
    pullup (sda_bus);

    always #10 CLK = ~CLK;

    mpu_6050_i2c_target #(.DEV_ADDR(7'h68), .WHO_AM_I(8'h68)) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .IO_SCL    (scl),
        .IO_SDA    (sda_bus),
        .I_LD_EN   (ld_en),
        .I_LD_ADDR (ld_addr),
        .I_LD_DATA (ld_data),
        .O_WR_STB  (wr_stb),
        .O_WR_ADDR (wr_addr),
        .O_WR_DATA (wr_data),
        .O_BUSY    (busy)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  model [128];
    logic [6:0]  mptr;
    logic [14:0] exp_stb [$];
    logic [7:0]  wbuf [4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 128; i++) model[i] = (i == 8'h6B) ? 8'h40 : 8'h00;
        mptr = '0;
        exp_stb.delete();
    endfunction

    function automatic logic [7:0] model_rd(input logic [6:0] a);
        return (a == 7'h75) ? 8'h68 : model[a];
    endfunction

    always @(negedge CLK) begin
        if (RST_n && wr_stb === 1'b1) begin
            logic [14:0] e;
            check_eq("stb_expected", exp_stb.size() != 0, 1);
            if (exp_stb.size() != 0) begin
                e = exp_stb.pop_front();
                check_eq("stb_addr", wr_addr, e[14:8]);
                check_eq("stb_data", wr_data, e[7:0]);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // One bit: drive while SCL low, raise SCL, sample just before the fall.
    task automatic i2c_bit(input logic b, input bit ld_hit, output logic smp);
        m_sda = b;
        wait_clk(T);
        scl = 1'b1;
        if (ld_hit) begin
            wait_clk(2);
            ld_en = 1'b1; ld_addr = 7'h3C; ld_data = 8'h11;
            wait_clk(1);
            ld_en = 1'b0;
            check_eq("stb_cycle", wr_stb, 1);
            wait_clk(T - 3);
        end else begin
            wait_clk(T);
        end
        smp = sda_bus;
        scl = 1'b0;
        wait_clk(T);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_clk(T);
        scl = 1'b1;   wait_clk(T);
        m_sda = 1'b0; wait_clk(T);
        scl = 1'b0;   wait_clk(T);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_clk(T);
        scl = 1'b1;   wait_clk(T);
        m_sda = 1'b1; wait_clk(T);
    endtask

    task automatic i2c_wbyte(input logic [7:0] b, input bit ld_hit, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], ld_hit && (i == 0), s);
        i2c_bit(1'b1, 1'b0, s);
        ack = ~s;
    endtask

    task automatic i2c_rbyte(input logic nack, output logic [7:0] d, output logic rel);
        logic s;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            i2c_bit(1'b1, 1'b0, s);
            d = {d[6:0], s};
        end
        i2c_bit(nack, 1'b0, rel);
    endtask

    task automatic txn_write(input logic [7:0] regb, input int n, input int ld_idx);
        logic ack;
        i2c_start();
        i2c_wbyte(8'hD0, 1'b0, ack);
        check_eq("w_addr_ack", ack, 1);
        i2c_wbyte(regb, 1'b0, ack);
        check_eq("w_ptr_ack", ack, 1);
        mptr = regb[6:0];
        for (int i = 0; i < n; i++) begin
            if (mptr != 7'h75) begin
                model[mptr] = wbuf[i];
                exp_stb.push_back({mptr, wbuf[i]});
            end
            i2c_wbyte(wbuf[i], i == ld_idx, ack);
            check_eq("w_data_ack", ack, 1);
            mptr = mptr + 7'd1;
        end
        i2c_stop();
    endtask

    task automatic txn_read(input logic [6:0] regp, input int n, input bit set_ptr);
        logic       ack, rel;
        logic [7:0] d;
        if (set_ptr) begin
            i2c_start();
            i2c_wbyte(8'hD0, 1'b0, ack);
            check_eq("r_waddr_ack", ack, 1);
            i2c_wbyte({1'b0, regp}, 1'b0, ack);
            check_eq("r_ptr_ack", ack, 1);
            mptr = regp;
        end
        i2c_start();
        i2c_wbyte(8'hD1, 1'b0, ack);
        check_eq("r_addr_ack", ack, 1);
        for (int i = 0; i < n; i++) begin
            i2c_rbyte(i == n - 1, d, rel);
            check_eq("r_data", d, model_rd(mptr));
            mptr = mptr + 7'd1;
        end
        check_eq("r_sda_released", rel, 1);
        check_eq("r_busy_before_p", busy, 1);
        i2c_stop();
        check_eq("r_busy_after_p", busy, 0);
    endtask

    task automatic fab_load(input logic [6:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        wait_clk(1);
        ld_en = 1'b0;
        if (a != 7'h75) model[a] = d;
        wait_clk(1);
    endtask

    initial begin
        logic ack;
        model_reset();
        wait_clk(3);
        RST_n = 1'b1;
        wait_clk(4);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_stb", wr_stb, 0);
        check_eq("rst_wr_addr", wr_addr, 0);
        check_eq("rst_wr_data", wr_data, 0);
        check_eq("rst_sda", sda_bus, 1);

        txn_read(7'h75, 1, 1'b1);

        txn_read(7'h6B, 1, 1'b1);
        wbuf[0] = 8'h00; wbuf[1] = 8'h12;
        txn_write(8'h6B, 2, -1);
        txn_read(7'h6B, 2, 1'b1);

        i2c_start();
        i2c_wbyte(8'hD2, 1'b0, ack);
        check_eq("other_addr_nack", ack, 0);
        check_eq("other_addr_busy", busy, 0);
        i2c_wbyte(8'h00, 1'b0, ack);
        check_eq("ignore_byte1_nack", ack, 0);
        i2c_wbyte(8'h12, 1'b0, ack);
        check_eq("ignore_byte2_nack", ack, 0);
        check_eq("ignore_busy", busy, 0);
        i2c_stop();

        wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
        txn_write(8'h7F, 2, -1);
        txn_read(7'h7E, 3, 1'b1);

        fab_load(7'h3B, 8'h12);
        txn_read(7'h3B, 1, 1'b1);
        wbuf[0] = 8'h22;
        txn_write(8'h3C, 1, 0);
        txn_read(7'h3C, 1, 1'b1);

        // Reset while the target drives a read data 0 (MSB of 0x12).
        i2c_start();
        i2c_wbyte(8'hD0, 1'b0, ack);
        i2c_wbyte(8'h3B, 1'b0, ack);
        i2c_start();
        i2c_wbyte(8'hD1, 1'b0, ack);
        check_eq("rd_msb_driven", sda_bus, 0);
        #3;
        RST_n = 1'b0;
        #1;
        check_eq("rst_async_sda", sda_bus, 1);
        check_eq("rst_async_busy", busy, 0);
        wait_clk(2);
        RST_n = 1'b1;
        model_reset();
        m_sda = 1'b1; wait_clk(T);
        scl = 1'b1;   wait_clk(T);
        check_eq("rst2_wr_addr", wr_addr, 0);
        check_eq("rst2_wr_data", wr_data, 0);
        txn_read(7'h00, 1, 1'b0);
        txn_read(7'h3B, 1, 1'b1);
        txn_read(7'h6B, 1, 1'b1);

        for (int it = 0; it < 16; it++) begin
            int op, n;
            op = $urandom_range(0, 2);
            n  = $urandom_range(1, 3);
            if (op == 0) begin
                for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
                txn_write(8'($urandom), n, -1);
            end else if (op == 1) begin
                txn_read(7'($urandom), n, $urandom_range(0, 1) == 1);
            end else begin
                fab_load(7'($urandom), 8'($urandom));
            end
        end

        wait_clk(4);
        check_eq("stb_queue_drained", exp_stb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
